coffee_dispenser: RTL

Brew-side responder for the coffee vending controller's brew handshake. It waits for the controller's `coffee_make` request and then runs a timed sequence: drop cup, confirm cup, heat, pour. When the sequence completes it returns the one-cycle `coffee_out` completion pulse the controller waits on. It sits between the vending controller and the machine's actuators and sensors, and also keeps a count of completed cups.

---
 rtl/coffee_dispenser.sv | 139 +++++++++++++
 1 files changed

// File: rtl/coffee_dispenser.sv
// Brew-side responder for the vending controller's coffee_make / coffee_out handshake.
// Define DISPENSER_ABORT_EN to let a dropped request abort CUP/HEAT/POUR back to IDLE.
module coffee_dispenser #(
    parameter int unsigned CUP_CYCLES  = 4,
    parameter int unsigned CUP_TIMEOUT = 16,
    parameter int unsigned HEAT_CYCLES = 8,
    parameter int unsigned POUR_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coffee_make,
    input  logic       cup_present,
    output logic       coffee_out,
    output logic       cup_drop,
    output logic       heater_on,
    output logic       water_valve,
    output logic       busy,
    output logic       fault,
    output logic [7:0] brew_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CUP     = 3'd1,
        S_HEAT    = 3'd2,
        S_POUR    = 3'd3,
        S_DONE    = 3'd4,
        S_RELEASE = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

`ifdef DISPENSER_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    localparam logic [31:0] CUP_DROP_LEN = 32'(CUP_CYCLES);
    localparam logic [31:0] CUP_LAST     = 32'(CUP_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(CUP_TIMEOUT - 1);
    localparam logic [31:0] HEAT_LAST    = 32'(HEAT_CYCLES - 1);
    localparam logic [31:0] POUR_LAST    = 32'(POUR_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_timer;
    logic        r_make_q;
    logic [7:0]  r_brew_count;
    logic        w_start;
    logic        w_abort;

    assign w_start = coffee_make & ~r_make_q;
    assign w_abort = ABORT_EN & ~coffee_make;

    // NOTE: all state here is sequential and uses non-blocking assignments so every
    // branch sees the pre-edge values of r_state and r_timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_make_q     <= 1'b0;
            r_brew_count <= '0;
        end else begin
            r_make_q <= coffee_make;
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (w_start) r_state <= S_CUP;
                end
                S_CUP: begin
                    // Cup arrival is checked before the timeout so it wins a tie.
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_timer <= '0;
                    end else if ((r_timer >= CUP_LAST) && cup_present) begin
                        r_state <= S_HEAT;
                        r_timer <= '0;
                    end else if (r_timer == TIMEOUT_LAST) begin
                        r_state <= S_FAULT;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_HEAT: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_timer <= '0;
                    end else if (r_timer == HEAT_LAST) begin
                        r_state <= S_POUR;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_POUR: begin
                    // Pour time only accumulates while a cup is actually under the spout.
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_timer <= '0;
                    end else if (cup_present) begin
                        if (r_timer == POUR_LAST) begin
                            r_state <= S_DONE;
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + 32'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_brew_count <= r_brew_count + 8'd1;
                    r_state      <= S_RELEASE;
                    r_timer      <= '0;
                end
                S_RELEASE: begin
                    r_timer <= '0;
                    if (!coffee_make) r_state <= S_IDLE;
                end
                S_FAULT: begin
                    r_timer <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // Moore decode straight from the async-reset state, so reset drops actuators at once.
    assign coffee_out  = (r_state == S_DONE);
    assign cup_drop    = (r_state == S_CUP) && (r_timer < CUP_DROP_LEN);
    assign heater_on   = (r_state == S_HEAT) || (r_state == S_POUR);
    assign water_valve = (r_state == S_POUR) && cup_present;
    assign busy        = (r_state == S_CUP) || (r_state == S_HEAT) || (r_state == S_POUR) ||
                         (r_state == S_DONE) || (r_state == S_RELEASE);
    assign fault       = (r_state == S_FAULT);
    assign brew_count  = r_brew_count;

endmodule
